// File: rtl/bcd_conv_arbiter_if.sv
// Request/response bundle between the BCD converter arbiter, its clients and the shared converter.
// The arbiter uses the slave modport; the client/converter side uses master.
interface bcd_conv_arbiter_if #(
   parameter int NREQ = 4
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]      req;
   logic [20*NREQ-1:0]   req_data;
   logic [NREQ-1:0]      ack;
   logic                 busy;
   logic [19:0]          conv_data;
   logic [3:0]           conv_unit;
   logic [3:0]           conv_ten;
   logic [3:0]           conv_hun;
   logic [3:0]           conv_tho;
   logic [3:0]           conv_t_tho;
   logic [3:0]           conv_h_hun;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [23:0]          rsp_bcd;
   logic                 rsp_ovf;

   modport slave (
      input  req, req_data,
      input  conv_unit, conv_ten, conv_hun, conv_tho, conv_t_tho, conv_h_hun,
      output ack, busy, conv_data,
      output rsp_valid, rsp_id, rsp_bcd, rsp_ovf
   );

   modport master (
      output req, req_data,
      output conv_unit, conv_ten, conv_hun, conv_tho, conv_t_tho, conv_h_hun,
      input  ack, busy, conv_data,
      input  rsp_valid, rsp_id, rsp_bcd, rsp_ovf
   );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one free-running serial binary-to-BCD converter among NREQ clients.
// Holds the granted (clamped) operand for WAIT_CYCLES, then returns the digits tagged with the client id.
module bcd_conv_arbiter #(
   parameter int NREQ        = 4,
   parameter int WAIT_CYCLES = 90
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   bcd_conv_arbiter_if.slave    bus
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW  = $clog2(WAIT_CYCLES);
   localparam logic [19:0] MAX_VAL = 20'd999_999;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [IDW-1:0]  ptr_reg, ptr_next;
   logic [IDW-1:0]  id_hold_reg, id_hold_next;
   logic            ovf_hold_reg, ovf_hold_next;
   logic [19:0]     conv_data_reg, conv_data_next;
   logic [NREQ-1:0] ack_reg, ack_next;
   logic            rsp_valid_reg, rsp_valid_next;
   logic [IDW-1:0]  rsp_id_reg, rsp_id_next;
   logic [23:0]     rsp_bcd_reg, rsp_bcd_next;
   logic            rsp_ovf_reg, rsp_ovf_next;

   logic [19:0]     operand [NREQ];
   logic            grant_found;
   logic [IDW-1:0]  grant_idx;
   logic [19:0]     grant_data;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_operand
         assign operand[gi] = bus.req_data[20*gi +: 20];
      end
   endgenerate

   // First set request at or above the pointer, wrapping around.
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_reg) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!grant_found && bus.req[idx]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(idx);
         end
      end
      grant_data = operand[grant_idx];
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      ptr_next       = ptr_reg;
      id_hold_next   = id_hold_reg;
      ovf_hold_next  = ovf_hold_reg;
      conv_data_next = conv_data_reg;
      ack_next       = '0;
      rsp_valid_next = 1'b0;
      rsp_id_next    = rsp_id_reg;
      rsp_bcd_next   = rsp_bcd_reg;
      rsp_ovf_next   = rsp_ovf_reg;
      case (state_reg)
         IDLE: begin
            if (grant_found) begin
               ack_next       = NREQ'(1) << grant_idx;
               conv_data_next = (grant_data > MAX_VAL) ? MAX_VAL : grant_data;
               ovf_hold_next  = (grant_data > MAX_VAL);
               id_hold_next   = grant_idx;
               ptr_next       = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
               cnt_next       = '0;
               state_next     = WAIT;
            end
         end
         WAIT: begin
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == CW'(WAIT_CYCLES - 1)) begin
               rsp_bcd_next = {bus.conv_h_hun, bus.conv_t_tho, bus.conv_tho,
                               bus.conv_hun, bus.conv_ten, bus.conv_unit};
               rsp_id_next  = id_hold_reg;
               rsp_ovf_next = ovf_hold_reg;
               state_next   = DONE;
            end
         end
         DONE: begin
            rsp_valid_next = 1'b1;
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         ptr_reg       <= '0;
         id_hold_reg   <= '0;
         ovf_hold_reg  <= 1'b0;
         conv_data_reg <= '0;
         ack_reg       <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_bcd_reg   <= '0;
         rsp_ovf_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         ptr_reg       <= ptr_next;
         id_hold_reg   <= id_hold_next;
         ovf_hold_reg  <= ovf_hold_next;
         conv_data_reg <= conv_data_next;
         ack_reg       <= ack_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_id_reg    <= rsp_id_next;
         rsp_bcd_reg   <= rsp_bcd_next;
         rsp_ovf_reg   <= rsp_ovf_next;
      end
   end

   assign bus.ack       = ack_reg;
   assign bus.busy      = (state_reg != IDLE);
   assign bus.conv_data = conv_data_reg;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_id    = rsp_id_reg;
   assign bus.rsp_bcd   = rsp_bcd_reg;
   assign bus.rsp_ovf   = rsp_ovf_reg;
endmodule
